frame_word_bank_writer: RTL

- Downstream stage of the packet byte parser; consumes its 16-bit payload words (`word_wren`/`word_data`) and its frame-enable level.
- Writes each frame into one bank of a 2-bank (ping-pong) dual-port RAM and generates the write addresses.
- Tracks which banks are full and reports completed frames to the DSP/readout side, which releases a bank once it has been read.

---
 rtl/mbo_frame_pkg.sv | 20 ++
 rtl/frame_bank_tracker.sv | 49 ++++
 rtl/frame_word_bank_writer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mbo_frame_pkg.sv
// Shared constants and state encoding for the parser / frame bank writer path.
// Pure declarations: no logic, no latency, no flow control.
package mbo_frame_pkg;

    localparam int WORDS_PER_FRAME = 200;
    localparam int HDR_BYTES       = 124;
    localparam int PAYLOAD_BYTES   = 400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DROP = 2'd2
    } frame_state_t;

    // One-hot mask selecting bank b of the ping-pong pair.
    function automatic logic [1:0] bank_mask(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/frame_bank_tracker.sv
// Ping-pong bank ownership: full flags, fill-bank selection, reader release, drop counter.
// Latency: flags/bank/counter update one cycle after start/commit/release; grant is combinational.
// Backpressure: none; when both banks are full a start is refused and counted as a drop.
module frame_bank_tracker
    import mbo_frame_pkg::*;
#(
    parameter int DROP_W = 8
) (
    input  logic              clock,
    input  logic              sclr,
    input  logic              start,
    input  logic              commit,
    input  logic              filling,
    input  logic [1:0]        rd_release,
    output logic              grant,
    output logic              cur_bank,
    output logic [1:0]        bank_full,
    output logic [DROP_W-1:0] drop_count
);

    logic [1:0] rel_eff;
    logic [1:0] full_nxt;

    always_comb begin
        grant    = ~(&bank_full);
        // The bank under fill never reads as full, but guard it explicitly anyway.
        rel_eff  = rd_release & bank_full & (filling ? ~bank_mask(cur_bank) : 2'b11);
        full_nxt = (bank_full & ~rel_eff) | (commit ? bank_mask(cur_bank) : 2'b00);
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            bank_full  <= 2'b00;
            cur_bank   <= 1'b0;
            drop_count <= '0;
        end else begin
            bank_full <= full_nxt;
            if (commit) begin
                cur_bank <= ~cur_bank;
            end else if (start && bank_full[cur_bank] && !bank_full[~cur_bank]) begin
                cur_bank <= ~cur_bank;
            end
            if (start && (&bank_full) && (drop_count != {DROP_W{1'b1}})) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_word_bank_writer.sv
// Writes parser payload words into a 2-bank ping-pong RAM and reports committed frames (FRAME_SUM_EN adds a checksum).
// Latency: accepted word reaches the RAM port 1 cycle later; frame_done pulses 1 cycle after frame_ena falls.
// Backpressure: none; words past WORDS_PER_FRAME are dropped (overrun) and whole frames drop when both banks are full.
module frame_word_bank_writer
    import mbo_frame_pkg::*;
#(
    parameter int WORDS_PER_FRAME = mbo_frame_pkg::WORDS_PER_FRAME,
    parameter int ADDR_W          = 8,
    parameter int DROP_W          = 8
) (
    input  logic              clock,
    input  logic              sclr,
    input  logic              frame_ena,
    input  logic              word_wren,
    input  logic [15:0]       word_data,
    input  logic [1:0]        rd_release,
    output logic              ram_wren,
    output logic [ADDR_W:0]   ram_addr,
    output logic [15:0]       ram_data,
    output logic [1:0]        bank_full,
    output logic              frame_done,
    output logic              last_bank,
    output logic [ADDR_W:0]   last_len,
    output logic              overrun,
    output logic [DROP_W-1:0] drop_count,
    output logic [15:0]       frame_sum
);

    localparam logic [ADDR_W:0] WPF_L = (ADDR_W + 1)'(WORDS_PER_FRAME);

    frame_state_t    state;
    logic            ena_d;
    logic [ADDR_W:0] wcnt;
    logic [ADDR_W:0] wcnt_nxt;
    logic            rise;
    logic            fall;
    logic            start;
    logic            accept;
    logic            over;
    logic            commit;
    logic            grant;
    logic            cur_bank;

    always_comb begin
        rise     = frame_ena & ~ena_d;
        fall     = ~frame_ena & ena_d;
        start    = (state == IDLE) & rise;
        // word_wren still counts on the fall cycle so the parser's last registered word lands.
        accept   = (state == FILL) & word_wren & (wcnt < WPF_L);
        over     = (state == FILL) & word_wren & ~(wcnt < WPF_L);
        wcnt_nxt = wcnt + {{ADDR_W{1'b0}}, accept};
        commit   = (state == FILL) & fall & (wcnt_nxt != '0);
    end

    frame_bank_tracker #(
        .DROP_W(DROP_W)
    ) u_tracker (
        .clock      (clock),
        .sclr       (sclr),
        .start      (start),
        .commit     (commit),
        .filling    (state == FILL),
        .rd_release (rd_release),
        .grant      (grant),
        .cur_bank   (cur_bank),
        .bank_full  (bank_full),
        .drop_count (drop_count)
    );

    always_ff @(posedge clock) begin
        if (sclr) begin
            state      <= IDLE;
            ena_d      <= 1'b0;
            wcnt       <= '0;
            ram_wren   <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
            frame_done <= 1'b0;
            last_bank  <= 1'b0;
            last_len   <= '0;
            overrun    <= 1'b0;
        end else begin
            ena_d      <= frame_ena;
            ram_wren   <= accept;
            frame_done <= commit;
            if (accept) begin
                ram_addr <= {cur_bank, wcnt[ADDR_W-1:0]};
                ram_data <= word_data;
            end
            if (commit) begin
                last_bank <= cur_bank;
                last_len  <= wcnt_nxt;
            end
            if (over) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (rise) begin
                        wcnt  <= '0;
                        state <= grant ? FILL : DROP;
                    end
                end
                FILL: begin
                    wcnt <= wcnt_nxt;
                    if (fall) begin
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (fall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FRAME_SUM_EN
    logic [15:0] sum_acc;
    logic [15:0] sum_nxt;

    always_comb begin
        sum_nxt = sum_acc + (accept ? word_data : 16'h0000);
    end

    // frame_sum only moves on commit so the reader sees a stable value per frame.
    always_ff @(posedge clock) begin
        if (sclr) begin
            sum_acc   <= 16'h0000;
            frame_sum <= 16'h0000;
        end else begin
            if (start) begin
                sum_acc <= 16'h0000;
            end else if (state == FILL) begin
                sum_acc <= sum_nxt;
            end
            if (commit) begin
                frame_sum <= sum_nxt;
            end
        end
    end
`else
    assign frame_sum = 16'h0000;
`endif

endmodule
